// File: rtl/usart_tx.sv
// USART transmitter: UDR holding buffer feeding a frame shift register that drives TXD
// with start, data (LSB first), optional parity and one or two stop bits.
module usart_tx #(
  parameter int DATA_BITS = 8,
  parameter int UBRR_W    = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              txen,
  input  logic [UBRR_W-1:0] ubrr,
  input  logic              u2x,
  input  logic [1:0]        upm,
  input  logic              usbs,
  input  logic              udr_wr,
  input  logic [7:0]        udr_din,
  input  logic              txc_clr,
  output logic              tx_out,
  output logic              udre,
  output logic              txc,
  output logic              busy
);

  localparam int BL_W = UBRR_W + 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] hold_q, shift_q;
  logic                 full_q;
  logic [BL_W-1:0]      bitlen_q, cnt_q;
  logic [2:0]           bidx_q;
  logic                 par_en_q, par_bit_q, two_stop_q, txc_q;
  logic                 bit_end, last_data, frame_end, do_load;

  function automatic logic [BL_W-1:0] calc_bitlen(input logic [UBRR_W-1:0] div,
                                                  input logic dbl);
    logic [BL_W-1:0] n;
    n = BL_W'(div) + BL_W'(1);
    return dbl ? (n << 3) : (n << 4);
  endfunction

  assign bit_end   = (cnt_q == bitlen_q - BL_W'(1));
  assign last_data = (bidx_q == 3'(DATA_BITS - 1));
  assign frame_end = bit_end && ((state == STOP1 && !two_stop_q) || state == STOP2);
  // A full buffer reloads straight out of the final stop bit, so back-to-back frames have no idle gap
  assign do_load   = full_q && txen && (state == IDLE || frame_end);

  assign udre = ~full_q;
  assign txc  = txc_q;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_load) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = par_en_q ? PARITY : STOP1;
      PARITY:  if (bit_end) state_nxt = STOP1;
      STOP1:   if (bit_end) state_nxt = two_stop_q ? STOP2 : (do_load ? START : IDLE);
      STOP2:   if (bit_end) state_nxt = do_load ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    busy   = (state != IDLE);
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = par_bit_q;
      default: tx_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      full_q     <= 1'b0;
      hold_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      bidx_q     <= '0;
      bitlen_q   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      txc_q      <= 1'b0;
    end else begin
      if (do_load) full_q <= 1'b0;
      else if (udr_wr && !full_q) begin
        full_q <= 1'b1;
        hold_q <= udr_din[DATA_BITS-1:0];
      end

      // Frame format and baud rate are frozen at load; the bit counter restarts every frame
      if (do_load) begin
        shift_q    <= hold_q;
        cnt_q      <= '0;
        bidx_q     <= '0;
        bitlen_q   <= calc_bitlen(ubrr, u2x);
        par_en_q   <= upm[1];
        par_bit_q  <= (^hold_q) ^ upm[0];
        two_stop_q <= usbs;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt_q <= '0;
          if (state == DATA) begin
            shift_q <= shift_q >> 1;
            bidx_q  <= bidx_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q + BL_W'(1);
        end
      end

      if (frame_end && !do_load) txc_q <= 1'b1;
      else if (txc_clr)          txc_q <= 1'b0;
    end
  end

endmodule
